// File: rtl/rob_walk_ctrl.sv
// rob_walk_ctrl: ROB rollback walker. It steps from the tail back toward a
// redirecting instruction and hands the squashed entries, up to two per cycle
// and youngest first, to rename-table and freelist rollback. It then pulses a
// tail reload to just past the surviving redirect target.
module rob_walk_ctrl #(
    parameter int ROB_SIZE_LOG = 6,
    parameter int LREG_W       = 5,
    parameter int PREG_W       = 6
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    redirect_valid,
    input  logic                    redirect_robidx_flag,
    input  logic [ROB_SIZE_LOG-1:0] redirect_robidx,
    input  logic                    enq_flag,
    input  logic [ROB_SIZE_LOG-1:0] enq_idx,
    output logic [ROB_SIZE_LOG-1:0] walk0_idx,
    output logic [ROB_SIZE_LOG-1:0] walk1_idx,
    input  logic [LREG_W-1:0]       walk0_rd_lrd,
    input  logic [LREG_W-1:0]       walk1_rd_lrd,
    input  logic [PREG_W-1:0]       walk0_rd_prd,
    input  logic [PREG_W-1:0]       walk1_rd_prd,
    input  logic [PREG_W-1:0]       walk0_rd_old_prd,
    input  logic [PREG_W-1:0]       walk1_rd_old_prd,
    output logic                    walk0_valid,
    output logic                    walk1_valid,
    output logic [LREG_W-1:0]       walk0_lrd,
    output logic [LREG_W-1:0]       walk1_lrd,
    output logic [PREG_W-1:0]       walk0_prd,
    output logic [PREG_W-1:0]       walk1_prd,
    output logic [PREG_W-1:0]       walk0_old_prd,
    output logic [PREG_W-1:0]       walk1_old_prd,
    output logic                    enq_block,
    output logic                    tail_restore_valid,
    output logic                    tail_restore_flag,
    output logic [ROB_SIZE_LOG-1:0] tail_restore_idx
);

    localparam int PTR_W = ROB_SIZE_LOG + 1;
    typedef logic [PTR_W-1:0] ptr_t;
    typedef enum logic [1:0] {IDLE, WALK, DONE} state_t;

    state_t state_q, state_d;
    ptr_t   p_q, p_d;   // walk pointer: one past the next entry to roll back
    ptr_t   t_q, t_d;   // surviving redirect target
    ptr_t   r_q, r_d;   // entries still to roll back, all strictly younger than t_q

    ptr_t   redir_ptr, enq_ptr, n_step, p_dec, r_redir, r_init;
    logic   w0_v, w1_v, take_redir;

    // Flag-aware age compare: same lap compares indices directly, different
    // laps reverse the sense because the younger pointer has wrapped.
    function automatic logic is_older(input ptr_t a, input ptr_t b);
        if (a[PTR_W-1] == b[PTR_W-1]) return a[ROB_SIZE_LOG-1:0] < b[ROB_SIZE_LOG-1:0];
        else                          return a[ROB_SIZE_LOG-1:0] > b[ROB_SIZE_LOG-1:0];
    endfunction

    assign redir_ptr  = {redirect_robidx_flag, redirect_robidx};
    assign enq_ptr    = {enq_flag, enq_idx};
    assign w0_v       = (state_q == WALK) && (r_q != '0);
    assign w1_v       = (state_q == WALK) && (r_q >= ptr_t'(2));
    assign n_step     = ptr_t'(w0_v) + ptr_t'(w1_v);
    assign p_dec      = p_q - n_step;
    assign r_init     = enq_ptr - redir_ptr - ptr_t'(1);
    // A redirect mid-walk only matters if it squashes more than the current one.
    assign take_redir = redirect_valid && (state_q != IDLE) && is_older(redir_ptr, t_q);
    // Recount from the pointer as it stands after this cycle's rollback.
    assign r_redir    = p_dec - redir_ptr - ptr_t'(1);

    // State and pointer registers; reset abandons any walk in flight.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            p_q     <= '0;
            t_q     <= '0;
            r_q     <= '0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            t_q     <= t_d;
            r_q     <= r_d;
        end
    end

    // Next-state and pointer update logic.
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        t_d     = t_q;
        r_d     = r_q;
        case (state_q)
            IDLE: begin
                if (redirect_valid) begin
                    t_d     = redir_ptr;
                    p_d     = enq_ptr;
                    r_d     = r_init;
                    state_d = (r_init != '0) ? WALK : DONE;
                end
            end
            WALK: begin
                p_d = p_dec;
                if (take_redir) begin
                    t_d = redir_ptr;
                    r_d = r_redir;
                end else begin
                    r_d = r_q - n_step;
                end
                state_d = (r_d != '0) ? WALK : DONE;
            end
            DONE: begin
                if (take_redir) begin
                    t_d     = redir_ptr;
                    r_d     = r_redir;
                    state_d = (r_redir != '0) ? WALK : DONE;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output decode: walk slots live only in WALK, tail reload only in DONE.
    always_comb begin
        walk0_valid        = 1'b0;
        walk1_valid        = 1'b0;
        walk0_idx          = '0;
        walk1_idx          = '0;
        walk0_lrd          = '0;
        walk1_lrd          = '0;
        walk0_prd          = '0;
        walk1_prd          = '0;
        walk0_old_prd      = '0;
        walk1_old_prd      = '0;
        tail_restore_valid = 1'b0;
        tail_restore_flag  = 1'b0;
        tail_restore_idx   = '0;
        enq_block          = redirect_valid | (state_q != IDLE);
        if (state_q == WALK) begin
            walk0_valid   = w0_v;
            walk1_valid   = w1_v;
            walk0_idx     = ROB_SIZE_LOG'(p_q - ptr_t'(1));
            walk1_idx     = ROB_SIZE_LOG'(p_q - ptr_t'(2));
            walk0_lrd     = walk0_rd_lrd;
            walk1_lrd     = walk1_rd_lrd;
            walk0_prd     = walk0_rd_prd;
            walk1_prd     = walk1_rd_prd;
            walk0_old_prd = walk0_rd_old_prd;
            walk1_old_prd = walk1_rd_old_prd;
        end
        // An accepted older redirect in DONE restarts the walk, so the reload waits.
        if (state_q == DONE && !take_redir) begin
            tail_restore_valid                  = 1'b1;
            {tail_restore_flag, tail_restore_idx} = t_q + ptr_t'(1);
        end
    end

endmodule

// File: tb/tb_rob_walk_ctrl.sv
// tb_rob_walk_ctrl: scoreboard bench for rob_walk_ctrl. Per-cycle expectations
// are queued when a redirect scenario is set up and popped one per cycle.
module tb_rob_walk_ctrl;

    typedef logic [6:0] ptr_t;
    typedef struct {
        bit         v0;
        bit         v1;
        logic [5:0] i0;
        logic [5:0] i1;
        bit         rv;
        ptr_t       rp;
    } cyc_t;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       redirect_valid = 1'b0;
    logic       redirect_robidx_flag = 1'b0;
    logic [5:0] redirect_robidx = '0;
    logic       enq_flag = 1'b0;
    logic [5:0] enq_idx = '0;
    logic [5:0] walk0_idx, walk1_idx;
    logic [4:0] walk0_rd_lrd, walk1_rd_lrd, walk0_lrd, walk1_lrd;
    logic [5:0] walk0_rd_prd, walk1_rd_prd, walk0_prd, walk1_prd;
    logic [5:0] walk0_rd_old_prd, walk1_rd_old_prd, walk0_old_prd, walk1_old_prd;
    logic       walk0_valid, walk1_valid, enq_block;
    logic       tail_restore_valid, tail_restore_flag;
    logic [5:0] tail_restore_idx;

    int   n_vec = 0;
    int   n_err = 0;
    cyc_t exp_q[$];

    always #5 clock = ~clock;

    // ROB storage stub: entry contents are a fixed function of the index.
    function automatic logic [4:0] f_lrd(input logic [5:0] i);
        return i[4:0] ^ 5'h15;
    endfunction
    function automatic logic [5:0] f_prd(input logic [5:0] i);
        return i + 6'd7;
    endfunction
    function automatic logic [5:0] f_old(input logic [5:0] i);
        return ~i;
    endfunction

    assign walk0_rd_lrd     = f_lrd(walk0_idx);
    assign walk1_rd_lrd     = f_lrd(walk1_idx);
    assign walk0_rd_prd     = f_prd(walk0_idx);
    assign walk1_rd_prd     = f_prd(walk1_idx);
    assign walk0_rd_old_prd = f_old(walk0_idx);
    assign walk1_rd_old_prd = f_old(walk1_idx);

    rob_walk_ctrl dut (
        .clock(clock), .reset_n(reset_n),
        .redirect_valid(redirect_valid),
        .redirect_robidx_flag(redirect_robidx_flag),
        .redirect_robidx(redirect_robidx),
        .enq_flag(enq_flag), .enq_idx(enq_idx),
        .walk0_idx(walk0_idx), .walk1_idx(walk1_idx),
        .walk0_rd_lrd(walk0_rd_lrd), .walk1_rd_lrd(walk1_rd_lrd),
        .walk0_rd_prd(walk0_rd_prd), .walk1_rd_prd(walk1_rd_prd),
        .walk0_rd_old_prd(walk0_rd_old_prd), .walk1_rd_old_prd(walk1_rd_old_prd),
        .walk0_valid(walk0_valid), .walk1_valid(walk1_valid),
        .walk0_lrd(walk0_lrd), .walk1_lrd(walk1_lrd),
        .walk0_prd(walk0_prd), .walk1_prd(walk1_prd),
        .walk0_old_prd(walk0_old_prd), .walk1_old_prd(walk1_old_prd),
        .enq_block(enq_block),
        .tail_restore_valid(tail_restore_valid),
        .tail_restore_flag(tail_restore_flag),
        .tail_restore_idx(tail_restore_idx)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Queue the walk cycles that roll back every entry from p-1 down to t+1.
    task automatic push_walk(input ptr_t p, input ptr_t t);
        ptr_t cnt, a, b;
        cyc_t e;
        cnt = p - t - 7'd1;
        while (cnt != 0) begin
            a    = p - 7'd1;
            b    = p - 7'd2;
            e    = '{v0: 1'b1, v1: (cnt >= 7'd2), i0: a[5:0], i1: b[5:0], rv: 1'b0, rp: '0};
            exp_q.push_back(e);
            p   = p - (e.v1 ? 7'd2 : 7'd1);
            cnt = cnt - (e.v1 ? 7'd2 : 7'd1);
        end
    endtask

    task automatic push_quiet();
        cyc_t e;
        e = '{v0: 1'b0, v1: 1'b0, i0: '0, i1: '0, rv: 1'b0, rp: '0};
        exp_q.push_back(e);
    endtask

    task automatic push_restore(input ptr_t rp);
        cyc_t e;
        e = '{v0: 1'b0, v1: 1'b0, i0: '0, i1: '0, rv: 1'b1, rp: rp};
        exp_q.push_back(e);
    endtask

    task automatic drive_redirect(input ptr_t r);
        redirect_valid       = 1'b1;
        redirect_robidx_flag = r[6];
        redirect_robidx      = r[5:0];
    endtask

    // Issue a redirect from IDLE, optionally follow up with redirects in walk
    // cycles c2/c3 (-1 = none), and compare one queued expectation per cycle.
    task automatic run(input string name, input ptr_t enq, input ptr_t rd,
                       input int c2, input ptr_t r2, input int c3, input ptr_t r3);
        int   n;
        cyc_t e;
        @(negedge clock);
        enq_flag = enq[6];
        enq_idx  = enq[5:0];
        drive_redirect(rd);
        #1 check({name, ":enq_block_at_redirect"}, 32'(enq_block), 32'd1);
        n = exp_q.size();
        for (int k = 0; k < n; k++) begin
            @(negedge clock);
            redirect_valid = 1'b0;
            if (k == c2) drive_redirect(r2);
            if (k == c3) drive_redirect(r3);
            #1;
            e = exp_q.pop_front();
            check($sformatf("%s:c%0d:walk0_valid", name, k), 32'(walk0_valid), 32'(e.v0));
            check($sformatf("%s:c%0d:walk1_valid", name, k), 32'(walk1_valid), 32'(e.v1));
            check($sformatf("%s:c%0d:restore_valid", name, k), 32'(tail_restore_valid), 32'(e.rv));
            check($sformatf("%s:c%0d:enq_block", name, k), 32'(enq_block), 32'd1);
            if (e.v0) begin
                check($sformatf("%s:c%0d:walk0_idx", name, k), 32'(walk0_idx), 32'(e.i0));
                check($sformatf("%s:c%0d:walk0_lrd", name, k), 32'(walk0_lrd), 32'(f_lrd(e.i0)));
                check($sformatf("%s:c%0d:walk0_prd", name, k), 32'(walk0_prd), 32'(f_prd(e.i0)));
                check($sformatf("%s:c%0d:walk0_old", name, k), 32'(walk0_old_prd), 32'(f_old(e.i0)));
            end
            if (e.v1) begin
                check($sformatf("%s:c%0d:walk1_idx", name, k), 32'(walk1_idx), 32'(e.i1));
                check($sformatf("%s:c%0d:walk1_old", name, k), 32'(walk1_old_prd), 32'(f_old(e.i1)));
            end
            if (e.rv)
                check($sformatf("%s:c%0d:restore_ptr", name, k),
                      32'({tail_restore_flag, tail_restore_idx}), 32'(e.rp));
        end
        @(negedge clock);
        redirect_valid = 1'b0;
        #1;
        check({name, ":idle_enq_block"}, 32'(enq_block), 32'd0);
        check({name, ":idle_walk0_valid"}, 32'(walk0_valid), 32'd0);
        check({name, ":idle_restore_valid"}, 32'(tail_restore_valid), 32'd0);
    endtask

    initial begin
        // Reset state, with enq_block following redirect_valid only.
        #1;
        check("rst:walk0_valid", 32'(walk0_valid), 32'd0);
        check("rst:restore_valid", 32'(tail_restore_valid), 32'd0);
        check("rst:enq_block_low", 32'(enq_block), 32'd0);
        redirect_valid = 1'b1;
        #1 check("rst:enq_block_follows", 32'(enq_block), 32'd1);
        redirect_valid = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;

        // Basic two-wide walk.
        push_walk({1'b0, 6'd10}, {1'b0, 6'd5});
        push_restore({1'b0, 6'd6});
        run("basic", {1'b0, 6'd10}, {1'b0, 6'd5}, -1, '0, -1, '0);

        // Walk across the index wrap.
        push_walk({1'b1, 6'd2}, {1'b0, 6'd61});
        push_restore({1'b0, 6'd62});
        run("wrap", {1'b1, 6'd2}, {1'b0, 6'd61}, -1, '0, -1, '0);

        // Odd count: last cycle has walk1_valid low.
        push_walk({1'b0, 6'd10}, {1'b0, 6'd6});
        push_restore({1'b0, 6'd7});
        run("odd", {1'b0, 6'd10}, {1'b0, 6'd6}, -1, '0, -1, '0);

        // Empty walk: restore directly one cycle after the redirect.
        push_restore({1'b0, 6'd10});
        run("empty", {1'b0, 6'd10}, {1'b0, 6'd9}, -1, '0, -1, '0);

        // Nested: younger redirect ignored, older one extends the walk to idx 3.
        push_walk({1'b0, 6'd20}, {1'b0, 6'd2});
        push_restore({1'b0, 6'd3});
        run("nested", {1'b0, 6'd20}, {1'b0, 6'd5}, 0, {1'b0, 6'd15}, 1, {1'b0, 6'd2});

        // Older redirect in DONE suppresses the pulse and walks again.
        push_quiet();
        push_walk({1'b0, 6'd10}, {1'b0, 6'd7});
        push_restore({1'b0, 6'd8});
        run("done_redir", {1'b0, 6'd10}, {1'b0, 6'd9}, 0, {1'b0, 6'd7}, -1, '0);

        // Reset in the middle of a walk.
        @(negedge clock);
        enq_flag = 1'b0;
        enq_idx  = 6'd10;
        drive_redirect({1'b0, 6'd5});
        @(negedge clock);
        redirect_valid = 1'b0;
        #1 check("rstwalk:in_walk", 32'(walk0_valid), 32'd1);
        reset_n = 1'b0;
        #1;
        check("rstwalk:walk0_valid", 32'(walk0_valid), 32'd0);
        check("rstwalk:walk1_valid", 32'(walk1_valid), 32'd0);
        check("rstwalk:walk0_idx", 32'(walk0_idx), 32'd0);
        check("rstwalk:walk1_idx", 32'(walk1_idx), 32'd0);
        check("rstwalk:enq_block", 32'(enq_block), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            #1;
            check($sformatf("rstwalk:post%0d:restore_valid", k), 32'(tail_restore_valid), 32'd0);
            check($sformatf("rstwalk:post%0d:walk0_valid", k), 32'(walk0_valid), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
